// File: rtl/mt_rand_stream.sv
// Pulls words from the Mersenne-twister generator, optionally scales them into [0, bound),
// and queues them in a first-word-fall-through FIFO behind a valid/ready stream.
module mt_rand_stream #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [31:0]      bound,
  output logic             gen_trig,
  input  logic [31:0]      gen_num,
  input  logic             gen_ready,
  input  logic             gen_last,
  output logic [31:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] count,
  output logic             stall
);

  localparam int               PTR_W      = $clog2(DEPTH);
  localparam logic [CNT_W:0]   DEPTH_WIDE = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);

  logic             accValid_q, accValid_d;
  logic             capValid_q, capValid_d;
  logic [31:0]      capWord_q, capWord_d;
  logic [31:0]      capBound_q, capBound_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             stall_q, stall_d;
  logic             lastWait_q, lastWait_d;
  logic [31:0]      mem_q [DEPTH];

  logic [1:0]       pending;
  logic [CNT_W:0]   inFlight;
  logic             accept;
  logic             push;
  logic             pop;
  logic [31:0]      result;

  // Words already accepted still need a FIFO slot, so they count against the free space.
  always_comb begin
    pending  = {1'b0, accValid_q} + {1'b0, capValid_q};
    inFlight = {1'b0, count_q} + {{(CNT_W-1){1'b0}}, pending};
    gen_trig = en && gen_ready && !rst && (inFlight < DEPTH_WIDE);
    accept   = gen_trig && gen_ready;
    m_valid  = (count_q != '0);
    push     = capValid_q;
    pop      = m_valid && m_ready;
    m_data   = m_valid ? mem_q[rdPtr_q] : '0;
    count    = count_q;
    stall    = stall_q;
    if (capBound_q == '0) begin
      result = capWord_q;
    end else begin
      result = 32'((64'(capWord_q) * 64'(capBound_q)) >> 32);
    end
  end

  always_comb begin
    accValid_d = accept;
    capValid_d = accValid_q;
    capWord_d  = capWord_q;
    capBound_d = capBound_q;
    wrPtr_d    = wrPtr_q + PTR_W'(push);
    rdPtr_d    = rdPtr_q + PTR_W'(pop);
    count_d    = count_q;
    stall_d    = en && !gen_ready;
    lastWait_d = lastWait_q;
    if (accValid_q) begin
      capWord_d  = gen_num;
      capBound_d = bound;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    if (!gen_ready) begin
      lastWait_d = 1'b0;
    end
    if (accept && gen_last) begin
      lastWait_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accValid_q <= 1'b0;
      capValid_q <= 1'b0;
      capWord_q  <= '0;
      capBound_q <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      stall_q    <= 1'b0;
      lastWait_q <= 1'b0;
    end else begin
      accValid_q <= accValid_d;
      capValid_q <= capValid_d;
      capWord_q  <= capWord_d;
      capBound_q <= capBound_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      lastWait_q <= lastWait_d;
      assert (!(push && !pop && count_q == DEPTH_CNT))
        else $error("mt_rand_stream: push into a full FIFO");
      assert (!(lastWait_q && gen_trig && !gen_ready))
        else $error("mt_rand_stream: trigger while generator is regenerating");
    end
  end

  // Storage is not reset; m_data is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= result;
    end
  end

endmodule

// File: tb/tb_mt_rand_stream.sv
// Directed bench for mt_rand_stream: a DEPTH=4 instance for fill/scaling/boundary/throughput
// and a DEPTH=8 instance for the mid-stream reset scenario, sharing one generator model.
module tb_mt_rand_stream;

  logic        clk;
  logic        rst;
  logic        en4, en8;
  logic [31:0] bound;
  logic [31:0] genNum;
  logic        genReady, genLast, mReady;
  logic        trig4, trig8;
  logic [31:0] mData4, mData8;
  logic        mValid4, mValid8;
  logic [2:0]  count4;
  logic [3:0]  count8;
  logic        stall4, stall8;

  int          checks;
  int          errors;
  int          acceptCount;
  int          seqVal;
  logic        useSeq;
  logic        seqClear;
  logic [31:0] genWord;

  mt_rand_stream #(.DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .bound(bound), .gen_trig(trig4), .gen_num(genNum),
    .gen_ready(genReady), .gen_last(genLast), .m_data(mData4), .m_valid(mValid4),
    .m_ready(mReady), .count(count4), .stall(stall4)
  );

  mt_rand_stream #(.DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .bound(bound), .gen_trig(trig8), .gen_num(genNum),
    .gen_ready(genReady), .gen_last(genLast), .m_data(mData8), .m_valid(mValid8),
    .m_ready(mReady), .count(count8), .stall(stall8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator model: the word for an accept in cycle t is presented during cycle t+1.
  always @(posedge clk) begin
    if ((trig4 || trig8) && genReady) begin
      acceptCount <= acceptCount + 1;
      genNum      <= useSeq ? 32'(seqVal) : genWord;
      if (useSeq) seqVal <= seqVal + 1;
    end
    if (seqClear) seqVal <= 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drainAll();
    en4 = 1'b0;
    en8 = 1'b0;
    mReady = 1'b1;
    step(10);
    mReady = 1'b0;
  endtask

  task automatic test_reset();
    step(2);
    checks++; if (trig4 !== 1'b0 || trig8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_trig: got %b/%b expected 0/0", trig4, trig8); end
    rst = 1'b0;
    en4 = 1'b0;
    en8 = 1'b0;
    step(1);
    checks++; if (mValid4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_mvalid: got %b expected 0", mValid4); end
    checks++; if (count4 !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count4); end
    checks++; if (mData4 !== 32'd0) begin errors++; $display("[TB] FAIL reset_mdata: got %0h expected 0", mData4); end
    checks++; if (stall4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall4); end
    checks++; if (mValid8 !== 1'b0 || count8 !== 4'd0) begin errors++; $display("[TB] FAIL reset_dut8: got valid %b count %0d expected 0/0", mValid8, count8); end
  endtask

  task automatic test_fill();
    int startAcc;
    int popped;
    bit sawTrig;
    logic [31:0] got [6];
    bound = 32'd0;
    useSeq = 1'b1;
    seqClear = 1'b1;
    step(1);
    seqClear = 1'b0;
    startAcc = acceptCount;
    mReady = 1'b0;
    en4 = 1'b1;
    step(12);
    checks++; if (acceptCount - startAcc !== 4) begin errors++; $display("[TB] FAIL fill_accepts: got %0d expected 4", acceptCount - startAcc); end
    checks++; if (count4 !== 3'd4) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 4", count4); end
    checks++; if (trig4 !== 1'b0) begin errors++; $display("[TB] FAIL fill_trig_held: got %b expected 0", trig4); end
    checks++; if (mValid4 !== 1'b1 || mData4 !== 32'd1) begin errors++; $display("[TB] FAIL fill_head: got valid %b data %0h expected 1/1", mValid4, mData4); end
    mReady = 1'b1;
    popped = 0;
    sawTrig = 1'b0;
    for (int cyc = 0; cyc < 40 && popped < 6; cyc++) begin
      if (trig4) sawTrig = 1'b1;
      if (mValid4) begin
        got[popped] = mData4;
        popped++;
      end
      step(1);
    end
    checks++; if (popped !== 6) begin errors++; $display("[TB] FAIL fill_drain_budget: got %0d words expected 6", popped); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (got[i] !== 32'(i + 1)) begin errors++; $display("[TB] FAIL fill_order[%0d]: got %0h expected %0h", i, got[i], i + 1); end
    end
    checks++; if (sawTrig !== 1'b1) begin errors++; $display("[TB] FAIL fill_resume: got %b expected 1", sawTrig); end
    drainAll();
  endtask

  task automatic test_scaling();
    logic [31:0] vB [5];
    logic [31:0] vW [5];
    logic [31:0] vE [5];
    vB = '{32'd6,         32'd10,        32'd10, 32'd0,         32'hFFFF_FFFF};
    vW = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0,  32'hDEAD_BEEF, 32'hFFFF_FFFF};
    vE = '{32'd3,         32'd9,         32'd0,  32'hDEAD_BEEF, 32'hFFFF_FFFE};
    useSeq = 1'b0;
    mReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bound = vB[i];
      genWord = vW[i];
      en4 = 1'b1;
      #1;
      checks++; if (trig4 !== 1'b1) begin errors++; $display("[TB] FAIL scale_trig[%0d]: got %b expected 1", i, trig4); end
      step(1);
      en4 = 1'b0;
      checks++; if (mValid4 !== 1'b0) begin errors++; $display("[TB] FAIL scale_lat1[%0d]: got %b expected 0", i, mValid4); end
      step(1);
      checks++; if (mValid4 !== 1'b0) begin errors++; $display("[TB] FAIL scale_lat2[%0d]: got %b expected 0", i, mValid4); end
      bound = 32'd5;
      step(1);
      checks++; if (mValid4 !== 1'b1) begin errors++; $display("[TB] FAIL scale_lat3[%0d]: got %b expected 1", i, mValid4); end
      checks++; if (mData4 !== vE[i]) begin errors++; $display("[TB] FAIL scale_data[%0d]: got %0h expected %0h", i, mData4, vE[i]); end
      mReady = 1'b1;
      step(1);
      mReady = 1'b0;
      checks++; if (count4 !== 3'd0) begin errors++; $display("[TB] FAIL scale_pop[%0d]: got %0d expected 0", i, count4); end
    end
    bound = 32'd0;
  endtask

  task automatic test_block_boundary();
    int badTrig;
    int badStall;
    useSeq = 1'b1;
    mReady = 1'b1;
    genLast = 1'b1;
    en4 = 1'b1;
    #1;
    checks++; if (trig4 !== 1'b1) begin errors++; $display("[TB] FAIL last_trig: got %b expected 1", trig4); end
    step(1);
    genReady = 1'b0;
    genLast = 1'b0;
    #1;
    checks++; if (trig4 !== 1'b0 || stall4 !== 1'b0) begin errors++; $display("[TB] FAIL regen_entry: got trig %b stall %b expected 0/0", trig4, stall4); end
    badTrig = 0;
    badStall = 0;
    for (int c = 0; c < 1250; c++) begin
      step(1);
      if (trig4 !== 1'b0) badTrig++;
      if (stall4 !== 1'b1) badStall++;
    end
    checks++; if (badTrig !== 0) begin errors++; $display("[TB] FAIL regen_no_trig: got %0d trig cycles expected 0", badTrig); end
    checks++; if (badStall !== 0) begin errors++; $display("[TB] FAIL regen_stall: got %0d cycles without stall expected 0", badStall); end
    step(1);
    genReady = 1'b1;
    #1;
    checks++; if (trig4 !== 1'b1) begin errors++; $display("[TB] FAIL regen_resume: got %b expected 1", trig4); end
    checks++; if (stall4 !== 1'b1) begin errors++; $display("[TB] FAIL stall_registered: got %b expected 1", stall4); end
    step(1);
    checks++; if (stall4 !== 1'b0) begin errors++; $display("[TB] FAIL stall_clear: got %b expected 0", stall4); end
    drainAll();
  endtask

  task automatic test_back_to_back();
    int startAcc;
    int waited;
    int popped;
    int badData;
    int gaps;
    int trigMiss;
    int cyc;
    int expNext;
    useSeq = 1'b1;
    seqClear = 1'b1;
    step(1);
    seqClear = 1'b0;
    startAcc = acceptCount;
    mReady = 1'b0;
    en4 = 1'b1;
    waited = 0;
    while (count4 !== 3'd4 && waited < 20) begin
      step(1);
      waited++;
    end
    checks++; if (count4 !== 3'd4) begin errors++; $display("[TB] FAIL b2b_full: got %0d expected 4", count4); end
    mReady = 1'b1;
    expNext = 1;
    popped = 0;
    badData = 0;
    gaps = 0;
    trigMiss = 0;
    cyc = 0;
    while (popped < 1000 && cyc < 1200) begin
      if (mValid4) begin
        if (mData4 !== 32'(expNext)) badData++;
        expNext++;
        popped++;
      end else begin
        gaps++;
      end
      if (cyc >= 1 && trig4 !== 1'b1) trigMiss++;
      step(1);
      cyc++;
    end
    checks++; if (popped < 1000) begin errors++; $display("[TB] FAIL b2b_budget: got %0d words expected 1000", popped); end
    checks++; if (gaps !== 0) begin errors++; $display("[TB] FAIL b2b_gaps: got %0d idle cycles expected 0", gaps); end
    checks++; if (trigMiss !== 0) begin errors++; $display("[TB] FAIL b2b_trig: got %0d cycles without trig expected 0", trigMiss); end
    en4 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (mValid4) begin
        if (mData4 !== 32'(expNext)) badData++;
        expNext++;
        popped++;
      end
      step(1);
    end
    checks++; if (badData !== 0) begin errors++; $display("[TB] FAIL b2b_order: got %0d wrong words expected 0", badData); end
    checks++; if (popped !== acceptCount - startAcc) begin errors++; $display("[TB] FAIL b2b_no_loss: got %0d popped expected %0d", popped, acceptCount - startAcc); end
    mReady = 1'b0;
  endtask

  task automatic test_reset_midstream();
    int startAcc;
    useSeq = 1'b1;
    seqClear = 1'b1;
    step(1);
    seqClear = 1'b0;
    mReady = 1'b0;
    bound = 32'd0;
    startAcc = acceptCount;
    en8 = 1'b1;
    step(5);
    checks++; if (count8 !== 4'd3) begin errors++; $display("[TB] FAIL mid_count: got %0d expected 3", count8); end
    checks++; if (acceptCount - startAcc !== 5) begin errors++; $display("[TB] FAIL mid_accepts: got %0d expected 5", acceptCount - startAcc); end
    rst = 1'b1;
    #1;
    checks++; if (trig8 !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_trig: got %b expected 0", trig8); end
    step(1);
    rst = 1'b0;
    en8 = 1'b0;
    checks++; if (mValid8 !== 1'b0 || count8 !== 4'd0) begin errors++; $display("[TB] FAIL mid_cleared: got valid %b count %0d expected 0/0", mValid8, count8); end
    checks++; if (mData8 !== 32'd0) begin errors++; $display("[TB] FAIL mid_mdata: got %0h expected 0", mData8); end
    step(4);
    checks++; if (mValid8 !== 1'b0 || count8 !== 4'd0) begin errors++; $display("[TB] FAIL mid_late_dropped: got valid %b count %0d expected 0/0", mValid8, count8); end
    useSeq = 1'b0;
    genWord = 32'hA5A5_0001;
    en8 = 1'b1;
    #1;
    checks++; if (trig8 !== 1'b1) begin errors++; $display("[TB] FAIL mid_post_trig: got %b expected 1", trig8); end
    step(1);
    en8 = 1'b0;
    step(2);
    checks++; if (mValid8 !== 1'b1 || count8 !== 4'd1) begin errors++; $display("[TB] FAIL mid_post_count: got valid %b count %0d expected 1/1", mValid8, count8); end
    checks++; if (mData8 !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL mid_post_data: got %0h expected a5a50001", mData8); end
    mReady = 1'b1;
    step(1);
    mReady = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    acceptCount = 0;
    seqVal = 1;
    rst = 1'b1;
    en4 = 1'b1;
    en8 = 1'b1;
    bound = 32'd0;
    genReady = 1'b1;
    genLast = 1'b0;
    mReady = 1'b0;
    useSeq = 1'b1;
    seqClear = 1'b0;
    genWord = 32'd0;
    test_reset();
    test_fill();
    test_scaling();
    test_block_boundary();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/mt_rand_stream.md
MT_RAND_STREAM -- requirements
Module: mt_rand_stream

Purpose: sits downstream of the Mersenne-twister generator. Pulls words via its trig/ready/last handshake, optionally range-reduces them and buffers them behind a valid/ready stream.

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two and at least 4.
REQ-002 Parameter CNT_W, default $clog2(DEPTH)+1, width of the occupancy output.
REQ-003 clk  input  1  clock; every register SHALL be clocked on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  pull enable; when low, no new words are requested.
REQ-006 bound  input  32  range bound; 0 selects the raw word.
REQ-007 gen_trig  output  1  request-next-word pulse to the generator.
REQ-008 gen_num  input  32  generator word.
REQ-009 gen_ready  input  1  generator is in its extraction phase.
REQ-010 gen_last  input  1  generator is at the last word of the current block.
REQ-011 m_data  output  32  stream data.
REQ-012 m_valid  output  1  stream data valid.
REQ-013 m_ready  input  1  downstream accept.
REQ-014 count  output  CNT_W  FIFO occupancy.
REQ-015 stall  output  1  en high while gen_ready is low (generator regenerating).

Function
REQ-016 Generator contract: a word is accepted in cycle t when gen_trig && gen_ready; gen_num SHALL be sampled at the end of cycle t+1 only.
REQ-017 gen_trig SHALL equal en && gen_ready && !rst && (count + pending < DEPTH).
REQ-018 pending SHALL be the number of accepted words not yet written to the FIFO; its range is 0..2.
REQ-019 gen_trig SHALL be combinational and asserted at most once per cycle; back-to-back trigs SHALL be allowed.
REQ-020 After an accept with gen_last high, the block SHALL issue no further gen_trig until gen_ready returns high, by REQ-017.
REQ-021 Pipeline stage 1 (end of t+1): capture gen_num and sample bound into a capture register with a valid bit.
REQ-022 Pipeline stage 2 (end of t+2): write the result into the FIFO.
REQ-023 Result when the sampled bound is 0: the raw word.
REQ-024 Result when the sampled bound is nonzero: bits [63:32] of the unsigned 64-bit product word*bound, so the result is always less than bound.
REQ-025 Minimum latency from accept (cycle t) to m_valid high SHALL be 3 cycles (m_valid high in t+3) when the FIFO is empty.
REQ-026 The FIFO SHALL be first-word-fall-through; m_data SHALL show the head entry whenever m_valid is high.
REQ-027 m_valid SHALL equal (count != 0).
REQ-028 A pop SHALL occur when m_valid && m_ready.
REQ-029 Simultaneous push and pop SHALL leave count unchanged and preserve order; this SHALL also hold when count == DEPTH.
REQ-030 Pointers SHALL wrap modulo DEPTH.
REQ-031 Overflow SHALL be impossible by construction; a push at count == DEPTH without a pop is a checker error.
REQ-032 When en deasserts, in-flight words (pending) SHALL still complete into the FIFO.
REQ-033 A change of bound SHALL affect only words captured after it changes.
REQ-034 stall SHALL be registered: stall <= en && !gen_ready.

Reset
REQ-035 While rst is high, gen_trig SHALL be 0.
REQ-036 On the clock edge with rst high, count, pending, the capture valid bit, the FIFO pointers and stall SHALL clear to 0.
REQ-037 After that reset edge, m_valid SHALL read 0.
REQ-038 m_data SHALL be 0 after reset until the first push.
REQ-039 Reset mid-operation SHALL discard all buffered and in-flight words.
REQ-040 A gen_num arriving for a trig accepted before reset SHALL be ignored.

Verification
REQ-041 Fill: DEPTH=4, bound=0, generator model returns 1,2,3,... for each trig, m_ready=0 -> exactly 4 accepts, count=4, gen_trig then stays 0; raise m_ready -> outputs 1,2,3,4 in order, then pulls resume.
REQ-042 Scaling: bound=6, gen_num=0x80000000 -> m_data=3; bound=10, gen_num=0xFFFFFFFF -> m_data=9; bound=10, gen_num=0 -> m_data=0.
REQ-043 Block boundary: accept with gen_last=1, then gen_ready low for 1250 cycles -> no gen_trig and stall=1 throughout; resumes the cycle gen_ready rises.
REQ-044 Full concurrency: count=DEPTH with m_ready=1 continuously -> one pop per cycle, a new trig issued each cycle, no loss or duplication over 1000 words (scoreboard).
REQ-045 Reset mid-stream: count=3 and pending=2 when rst pulses one cycle -> next cycle m_valid=0, count=0; late gen_num not pushed; the first word after reset is the first post-reset accept.
